// File: rtl/camera_frame_capture_if.sv
// Camera parallel byte bus (VSYNC/HREF/D) as seen by the frame-capture block.
// The camera side drives the bus (master); the capture block only observes it (slave).
interface camera_frame_capture_if;
  logic       i_vsync;
  logic       i_href;
  logic [7:0] i_data;

  modport master (output i_vsync, output i_href, output i_data);
  modport slave  (input  i_vsync, input  i_href, input  i_data);
endinterface

// File: rtl/camera_frame_capture.sv
// Single-shot RGB565 frame grabber: waits for a clean frame start, writes every HREF byte
// into the frame RAM, then reports the frame length and holds a ready level until restarted.
module camera_frame_capture #(
  parameter int MAX_BYTES         = 19200,
  parameter int ADDR_W            = 15,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  camera_frame_capture_if.slave cam,
  output logic [ADDR_W-1:0]    o_RAM_adress,
  output logic [7:0]           o_RAM_data,
  output logic                 o_RAM_we,
  output logic [ADDR_W-1:0]    o_BytesPerFrame,
  output logic [7:0]           o_lines,
  output logic                 o_frame_ready,
  output logic                 o_busy,
  output logic                 o_overflow
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SYNC,
    ST_CAPTURE,
    ST_DONE,
    ST_READY
  } state_e;

  localparam logic [ADDR_W-1:0] MAX_CNT = ADDR_W'(MAX_BYTES);

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] cnt_q,       cnt_d;
  logic [7:0]        line_cnt_q,  line_cnt_d;
  logic              href_prev_q, href_prev_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        data_q,      data_d;
  logic              we_q,        we_d;
  logic [ADDR_W-1:0] bytes_q,     bytes_d;
  logic [7:0]        lines_q,     lines_d;
  logic              ready_q,     ready_d;
  logic              busy_q,      busy_d;
  logic              ovf_q,       ovf_d;

  logic blank;
  assign blank = (cam.i_vsync == VSYNC_ACTIVE_HIGH);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_cnt_d  = line_cnt_q;
    href_prev_d = href_prev_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    bytes_d     = bytes_q;
    lines_d     = lines_q;
    ready_d     = ready_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (i_start) begin
          state_d = ST_ARM;
          ready_d = 1'b0;
        end
      end
      // Wait for blanking first so a request never latches onto a frame already in flight.
      ST_ARM: begin
        if (blank) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!blank) begin
          state_d     = ST_CAPTURE;
          cnt_d       = '0;
          line_cnt_d  = '0;
          href_prev_d = 1'b0;
          ovf_d       = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (blank) begin
          state_d = ST_DONE;
        end else begin
          href_prev_d = cam.i_href;
          if (cam.i_href && !href_prev_q && (line_cnt_q != 8'hFF)) begin
            line_cnt_d = line_cnt_q + 8'd1;
          end
          if (cam.i_href) begin
            if (cnt_q < MAX_CNT) begin
              we_d   = 1'b1;
              addr_d = cnt_q;
              data_d = cam.i_data;
              cnt_d  = cnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        bytes_d = cnt_q;
        lines_d = line_cnt_q;
        ready_d = 1'b1;
        state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_READY);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      line_cnt_q  <= '0;
      href_prev_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      bytes_q     <= '0;
      lines_q     <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_cnt_q  <= line_cnt_d;
      href_prev_q <= href_prev_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      bytes_q     <= bytes_d;
      lines_q     <= lines_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_RAM_adress    = addr_q;
  assign o_RAM_data      = data_q;
  assign o_RAM_we        = we_q;
  assign o_BytesPerFrame = bytes_q;
  assign o_lines         = lines_q;
  assign o_frame_ready   = ready_q;
  assign o_busy          = busy_q;
  assign o_overflow      = ovf_q;

endmodule

// File: tb/tb_camera_frame_capture.sv
// Directed bench: three capture instances (default, 16-byte RAM, inverted VSYNC) on one
// shared camera stream, each started independently; writes are logged and compared.
module tb_camera_frame_capture;

  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vsync = 1'b1;
  logic href = 1'b0;
  logic [7:0] data = 8'h00;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  camera_frame_capture_if cam_ab ();
  camera_frame_capture_if cam_c ();
  assign cam_ab.i_vsync = vsync;
  assign cam_ab.i_href  = href;
  assign cam_ab.i_data  = data;
  assign cam_c.i_vsync  = ~vsync;
  assign cam_c.i_href   = href;
  assign cam_c.i_data   = data;

  logic [AW-1:0] a_addr, a_bytes, b_addr, b_bytes, c_addr, c_bytes;
  logic [7:0]    a_data, a_lines, b_data, b_lines, c_data, c_lines;
  logic          a_we, a_rdy, a_busy, a_ovf;
  logic          b_we, b_rdy, b_busy, b_ovf;
  logic          c_we, c_rdy, c_busy, c_ovf;

  camera_frame_capture dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .cam(cam_ab),
    .o_RAM_adress(a_addr), .o_RAM_data(a_data), .o_RAM_we(a_we),
    .o_BytesPerFrame(a_bytes), .o_lines(a_lines), .o_frame_ready(a_rdy),
    .o_busy(a_busy), .o_overflow(a_ovf));

  camera_frame_capture #(.MAX_BYTES(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .cam(cam_ab),
    .o_RAM_adress(b_addr), .o_RAM_data(b_data), .o_RAM_we(b_we),
    .o_BytesPerFrame(b_bytes), .o_lines(b_lines), .o_frame_ready(b_rdy),
    .o_busy(b_busy), .o_overflow(b_ovf));

  camera_frame_capture #(.VSYNC_ACTIVE_HIGH(1'b0)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_c), .cam(cam_c),
    .o_RAM_adress(c_addr), .o_RAM_data(c_data), .o_RAM_we(c_we),
    .o_BytesPerFrame(c_bytes), .o_lines(c_lines), .o_frame_ready(c_rdy),
    .o_busy(c_busy), .o_overflow(c_ovf));

  // Write logs, sampled mid-cycle.
  logic [AW-1:0] la_addr [64];
  logic [7:0]    la_data [64];
  logic [AW-1:0] lb_addr [64];
  logic [7:0]    lb_data [64];
  logic [AW-1:0] lc_addr [64];
  logic [7:0]    lc_data [64];
  int na = 0, nb = 0, nc = 0;

  always @(negedge clk) begin
    if (a_we) begin
      if (na < 64) begin la_addr[na] = a_addr; la_data[na] = a_data; end
      na = na + 1;
    end
    if (b_we) begin
      if (nb < 64) begin lb_addr[nb] = b_addr; lb_data[nb] = b_data; end
      nb = nb + 1;
    end
    if (c_we) begin
      if (nc < 64) begin lc_addr[nc] = c_addr; lc_data[nc] = c_data; end
      nc = nc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expects vsync already blank; ends with a few blank cycles so DONE/READY settle.
  task automatic frame(input int nlines, input int bpl, input logic [7:0] base);
    logic [7:0] d;
    d = base;
    vsync = 1'b0;
    tick(2);
    for (int l = 0; l < nlines; l++) begin
      href = 1'b1;
      for (int k = 0; k < bpl; k++) begin
        data = d;
        d = d + 8'd1;
        tick(1);
      end
      href = 1'b0;
      tick(2);
    end
    vsync = 1'b1;
    tick(4);
  endtask

  int base_a;

  initial begin
    tick(3);
    check("rst_addr",  32'(a_addr),  0);
    check("rst_data",  32'(a_data),  0);
    check("rst_we",    32'(a_we),    0);
    check("rst_bytes", 32'(a_bytes), 0);
    check("rst_lines", 32'(a_lines), 0);
    check("rst_ready", 32'(a_rdy),   0);
    check("rst_busy",  32'(a_busy),  0);
    check("rst_ovf",   32'(a_ovf),   0);
    rst_n = 1'b1;
    tick(2);

    // Basic 2 x 4-byte frame on dut_a.
    start_a = 1'b1; tick(1); start_a = 1'b0; tick(2);
    check("a_busy_armed", 32'(a_busy), 1);
    frame(2, 4, 8'h11);
    check("a1_nwrites", 32'(na), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("a1_addr%0d", i), 32'(la_addr[i]), 32'(i));
      check($sformatf("a1_data%0d", i), 32'(la_data[i]), 32'h11 + 32'(i));
    end
    check("a1_bytes", 32'(a_bytes), 8);
    check("a1_lines", 32'(a_lines), 2);
    check("a1_ready", 32'(a_rdy),   1);
    check("a1_ovf",   32'(a_ovf),   0);
    check("a1_busy",  32'(a_busy),  0);
    check("b_idle_nwrites", 32'(nb), 0);
    check("c_idle_nwrites", 32'(nc), 0);

    // Another frame while READY and no start: nothing written, length unchanged.
    frame(1, 6, 8'h40);
    check("a_ready_nwrites", 32'(na), 8);
    check("a_ready_bytes",   32'(a_bytes), 8);
    check("a_ready_held",    32'(a_rdy), 1);

    // Start mid-frame: must wait for blank then the next frame start.
    base_a = na;
    vsync = 1'b0; tick(2);
    href = 1'b1; data = 8'h90; tick(1);
    start_a = 1'b1; data = 8'h91; tick(1);
    start_a = 1'b0; data = 8'h92; tick(1);
    href = 1'b0; tick(2);
    href = 1'b1; data = 8'h93; tick(2);
    href = 1'b0; tick(1);
    check("a2_ready_cleared", 32'(a_rdy), 0);
    check("a2_busy",          32'(a_busy), 1);
    check("a2_no_midframe",   32'(na - base_a), 0);
    vsync = 1'b1; tick(3);
    check("a2_no_blank_write", 32'(na - base_a), 0);
    frame(2, 4, 8'h21);
    check("a2_nwrites",  32'(na - base_a), 8);
    check("a2_addr_first", 32'(la_addr[base_a]),     0);
    check("a2_data_first", 32'(la_data[base_a]),     32'h21);
    check("a2_addr_last",  32'(la_addr[base_a + 7]), 7);
    check("a2_data_last",  32'(la_data[base_a + 7]), 32'h28);
    check("a2_bytes", 32'(a_bytes), 8);
    check("a2_lines", 32'(a_lines), 2);
    check("a2_ready", 32'(a_rdy), 1);

    // Overflow on the 16-byte instance with a 20-byte frame.
    start_b = 1'b1; tick(1); start_b = 1'b0; tick(2);
    frame(2, 10, 8'h50);
    check("b_nwrites", 32'(nb), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("b_addr%0d", i), 32'(lb_addr[i]), 32'(i));
      check($sformatf("b_data%0d", i), 32'(lb_data[i]), 32'h50 + 32'(i));
    end
    check("b_ovf",   32'(b_ovf),   1);
    check("b_bytes", 32'(b_bytes), 16);
    check("b_lines", 32'(b_lines), 2);
    check("b_ready", 32'(b_rdy),   1);
    check("a_unaffected_nwrites", 32'(na - base_a), 8);

    // Inverted-VSYNC instance, 6-byte frame.
    start_c = 1'b1; tick(1); start_c = 1'b0; tick(2);
    frame(1, 6, 8'h61);
    check("c_nwrites", 32'(nc), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("c_addr%0d", i), 32'(lc_addr[i]), 32'(i));
      check($sformatf("c_data%0d", i), 32'(lc_data[i]), 32'h61 + 32'(i));
    end
    check("c_bytes", 32'(c_bytes), 6);
    check("c_lines", 32'(c_lines), 1);
    check("c_ready", 32'(c_rdy),   1);
    check("c_ovf",   32'(c_ovf),   0);

    // Asynchronous reset in the middle of a capture after 5 bytes.
    base_a = na;
    start_a = 1'b1; tick(1); start_a = 1'b0; tick(2);
    vsync = 1'b0; tick(2);
    href = 1'b1;
    for (int k = 0; k < 5; k++) begin
      data = 8'h71 + 8'(k);
      tick(1);
    end
    data = 8'h76;
    @(negedge clk); #1;
    check("r_pre_nwrites",  32'(na - base_a), 5);
    check("r_pre_lastdata", 32'(la_data[base_a + 4]), 32'h75);
    check("r_pre_busy",     32'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    check("r_addr",  32'(a_addr),  0);
    check("r_data",  32'(a_data),  0);
    check("r_we",    32'(a_we),    0);
    check("r_bytes", 32'(a_bytes), 0);
    check("r_lines", 32'(a_lines), 0);
    check("r_ready", 32'(a_rdy),   0);
    check("r_busy",  32'(a_busy),  0);
    check("r_ovf",   32'(a_ovf),   0);
    check("r_b_ready", 32'(b_rdy), 0);
    check("r_c_ready", 32'(c_rdy), 0);
    tick(2);
    rst_n = 1'b1;
    href = 1'b0;
    tick(1);
    vsync = 1'b1; tick(2);
    base_a = na;
    frame(1, 4, 8'h80);
    check("r_post_nwrites", 32'(na - base_a), 0);
    check("r_post_ready",   32'(a_rdy),  0);
    check("r_post_busy",    32'(a_busy), 0);
    check("r_post_bytes",   32'(a_bytes), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
